// File: rtl/temporizador_ctrl_pkg.sv
// Shared definitions for the programmable event timer: FSM state encoding and default widths.
package temporizador_ctrl_pkg;

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned PRESC_W_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/temporizador_ctrl_contador.sv
// N-bit counter with clear, count enable and runtime modulo; ov_o is a registered
// one-cycle wrap pulse, wrap_c_o is the same-cycle wrap condition for the controlling FSM.
module temporizador_ctrl_contador #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] mod_i,
  output logic [N-1:0] cnt_o,
  output logic         ov_o,
  output logic         wrap_c_o
);

  logic [N-1:0] cnt_q;
  logic         ov_q;

  // mod_i is never 0 while enabled, so mod_i-1 does not underflow in use
  assign wrap_c_o = en_i && (cnt_q == (mod_i - N'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= wrap_c_o;
      if (en_i) begin
        cnt_q <= wrap_c_o ? '0 : cnt_q + N'(1);
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ov_o  = ov_q;

endmodule

// File: rtl/temporizador_ctrl.sv
// Programmable event timer: start/stop FSM around a runtime-modulo counter, periodic or one-shot.
// Optional build macro TIMER_PRESC_EN adds a prescaler dividing the count rate by presc+1.
module temporizador_ctrl
  import temporizador_ctrl_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [N-1:0]       period,
  input  logic [PRESC_W-1:0] presc,
  output logic               busy,
  output logic               tick,
  output logic               done,
  output logic               err,
  output logic [N-1:0]       q
);

  state_e       state_q;
  logic         busy_q;
  logic         done_q;
  logic         err_q;
  logic         oneshot_q;
  logic [N-1:0] period_q;
  logic         run;
  logic         adv;
  logic         cnt_clr;
  logic         wrap;
  logic         start_ok;

  assign run      = (state_q == ST_RUN);
  assign start_ok = !run && start && !stop && (period != '0);

`ifdef TIMER_PRESC_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q;

  assign adv = run && (pcnt_q == presc_q);

  // Prescaler restarts from zero on every start, stop and each enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      if (start_ok) begin
        presc_q <= presc;
      end
      if (!run || stop || adv) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + PRESC_W'(1);
      end
    end
  end
`else
  logic unused_presc;

  assign unused_presc = ^presc;
  assign adv          = run;
`endif

  // Counter held at zero while idle; stop overrides a coincident wrap
  assign cnt_clr = !run || stop;

  temporizador_ctrl_contador #(
    .N(N)
  ) u_contador (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (adv),
    .mod_i    (period_q),
    .cnt_o    (q),
    .ov_o     (tick),
    .wrap_c_o (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      oneshot_q <= 1'b0;
      period_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            oneshot_q <= oneshot;
            period_q  <= period;
          end else if (start && !stop) begin
            err_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (oneshot_q && wrap) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_temporizador_ctrl.sv
// Self-checking bench for temporizador_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against an elapsed-count reference model.
module tb_temporizador_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          oneshot;
  logic [N-1:0]  period;
  logic [PW-1:0] presc;
  logic          busy;
  logic          tick;
  logic          done;
  logic          err;
  logic [N-1:0]  q;

  always #5 clk = ~clk;

  temporizador_ctrl #(
    .N       (N),
    .PRESC_W (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .oneshot (oneshot),
    .period  (period),
    .presc   (presc),
    .busy    (busy),
    .tick    (tick),
    .done    (done),
    .err     (err),
    .q       (q)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: count of enabled cycles since start; q = elapsed mod P
  bit m_run  = 1'b0;
  bit m_one  = 1'b0;
  int m_p    = 1;
  int m_el   = 0;
  bit e_tick = 1'b0;
  bit e_done = 1'b0;
  bit e_err  = 1'b0;
`ifdef TIMER_PRESC_EN
  int m_presc = 0;
  int m_cyc   = 0;
`endif

  task automatic model_step();
    bit adv;
    e_tick = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_el  = 0;
    end else if (!m_run) begin
      if (start && !stop) begin
        if (period != '0) begin
          m_run = 1'b1;
          m_p   = int'(period);
          m_one = oneshot;
          m_el  = 0;
`ifdef TIMER_PRESC_EN
          m_presc = int'(presc);
          m_cyc   = 0;
`endif
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (stop) begin
      m_run = 1'b0;
      m_el  = 0;
    end else begin
      adv = 1'b1;
`ifdef TIMER_PRESC_EN
      adv   = (((m_cyc + 1) % (m_presc + 1)) == 0);
      m_cyc = m_cyc + 1;
`endif
      if (adv) begin
        m_el = m_el + 1;
        if ((m_el % m_p) == 0) begin
          e_tick = 1'b1;
          if (m_one) begin
            e_done = 1'b1;
            m_run  = 1'b0;
            m_el   = 0;
          end
        end
      end
    end
  endtask

  function automatic int exp_q();
    return m_run ? (m_el % m_p) : 0;
  endfunction

  // Check the current cycle's outputs, then drive the next cycle's inputs
  task automatic step(input bit r, input bit s, input bit sp, input bit one,
                      input int per, input int pr);
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_run));
    check("tick", 32'(tick), 32'(e_tick));
    check("done", 32'(done), 32'(e_done));
    check("err",  32'(err),  32'(e_err));
    check("q",    32'(q),    32'(exp_q()));
    rst     = r;
    start   = s;
    stop    = sp;
    oneshot = one;
    period  = N'(per);
    presc   = PW'(pr);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic stop_at(input int qv);
    for (int i = 0; i < 600 && m_run && exp_q() != qv; i++) idle(1);
    check("stop_at_reached", 32'(exp_q()), 32'(qv));
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    oneshot = 1'b0;
    period  = '0;
    presc   = '0;
    repeat (2) @(posedge clk);

    // Reset state checked on the first step, then periodic P=4
    step(1'b0, 1'b1, 1'b0, 1'b0, 4, 1);
    idle(14);
    stop_at(2);
    idle(3);

    // One-shot P=3
    step(1'b0, 1'b1, 1'b0, 1'b1, 3, 0);
    idle(6);

    // Stop on the wrap cycle suppresses tick
    step(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    idle(3);
    stop_at(1);
    idle(3);

    // Zero period rejected, then a valid start
    step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(2);

    // Start with stop in IDLE does nothing; zero period with stop raises no err
    step(1'b0, 1'b1, 1'b1, 1'b0, 3, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    idle(3);

    // P=1 ticks every cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(2);

    // Reset mid-run, then restart
    step(1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
    idle(6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
    idle(7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // Maximum period one-shot
    step(1'b0, 1'b1, 1'b0, 1'b1, 255, 0);
    idle(260);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int per;
      per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)),
           per,
           int'($urandom_range(0, 3)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
